// File: rtl/result_formatter.sv
// result_formatter: signed binary result -> ASCII decimal byte stream.
// Shift-add-3 BCD conversion, leading-zero suppression, '-' prefix.
//
// Parameters:
//   W       width of the signed two's-complement input value
//   DIGITS  BCD digit count, 10^DIGITS must exceed 2^(W-1)
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   start, value         format request and the value captured with it
//   busy                 accepting edge until the final character transfers
//   out_char, out_valid  registered ASCII character and its valid flag
//   out_ready            consumer accepts out_char
//   out_last             final character of the number
//   done                 one-cycle pulse after the final transfer
// Build option:
//   RESULT_FORMATTER_NEWLINE_EN  append 0x0A after the last digit;
//                                out_last then marks the newline.

module result_formatter #(
    parameter int W      = 50,
    parameter int DIGITS = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic [7:0]   out_char,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         done
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam int IW = $clog2(DIGITS);

`ifdef RESULT_FORMATTER_NEWLINE_EN
    localparam bit NewlineEn = 1'b1;
    typedef enum logic [2:0] {
        IDLE, CONVERT, SIGN, EMIT, NEWLINE
    } state_t;
`else
    localparam bit NewlineEn = 1'b0;
    typedef enum logic [2:0] {
        IDLE, CONVERT, SIGN, EMIT
    } state_t;
`endif

    state_t        state, stateNxt;
    logic          neg, negNxt;
    logic [W-1:0]  mag, magNxt;
    logic [BW-1:0] bcd, bcdNxt, bcdAdj;
    logic [CW-1:0] cnt, cntNxt;
    logic [IW-1:0] idx, idxNxt, idxDec, msd;
    logic [7:0]    charNxt;
    logic          validNxt, lastNxt, busyNxt, doneNxt;
    logic          xfer;

    function automatic logic [7:0] asciiAt(
        input logic [BW-1:0] b,
        input logic [IW-1:0] i
    );
        return 8'h30 + {4'h0, b[4*i +: 4]};
    endfunction

    // Digit correction ahead of the shift: any digit >= 5 would
    // overflow past 9 when doubled, so pre-add 3.
    always_comb begin
        bcdAdj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcdAdj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Most significant nonzero digit; stays 0 for value 0 so that a
    // single "0" is emitted.
    always_comb begin
        msd = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] != 4'd0) begin
                msd = IW'(d);
            end
        end
    end

    assign idxDec = idx - IW'(1);
    assign xfer   = out_valid && out_ready;

    always_comb begin
        stateNxt = state;
        negNxt   = neg;
        magNxt   = mag;
        bcdNxt   = bcd;
        cntNxt   = cnt;
        idxNxt   = idx;
        charNxt  = out_char;
        validNxt = out_valid;
        lastNxt  = out_last;
        busyNxt  = busy;
        doneNxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    negNxt   = value[W-1];
                    // Unsigned reinterpretation makes -2^(W-1)
                    // come out as 2^(W-1) without overflow.
                    magNxt   = value[W-1] ? -value : value;
                    bcdNxt   = '0;
                    cntNxt   = CW'(W);
                    busyNxt  = 1'b1;
                    stateNxt = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt != '0) begin
                    {bcdNxt, magNxt} = {bcdAdj, mag} << 1;
                    cntNxt = cnt - CW'(1);
                end else begin
                    idxNxt   = msd;
                    validNxt = 1'b1;
                    if (neg) begin
                        charNxt  = 8'h2D;
                        lastNxt  = 1'b0;
                        stateNxt = SIGN;
                    end else begin
                        charNxt  = asciiAt(bcd, msd);
                        lastNxt  = (msd == '0) && !NewlineEn;
                        stateNxt = EMIT;
                    end
                end
            end
            SIGN: begin
                if (xfer) begin
                    charNxt  = asciiAt(bcd, idx);
                    lastNxt  = (idx == '0) && !NewlineEn;
                    stateNxt = EMIT;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (idx != '0) begin
                        idxNxt  = idxDec;
                        charNxt = asciiAt(bcd, idxDec);
                        lastNxt = (idxDec == '0) && !NewlineEn;
                    end else begin
`ifdef RESULT_FORMATTER_NEWLINE_EN
                        charNxt  = 8'h0A;
                        lastNxt  = 1'b1;
                        stateNxt = NEWLINE;
`else
                        validNxt = 1'b0;
                        lastNxt  = 1'b0;
                        busyNxt  = 1'b0;
                        doneNxt  = 1'b1;
                        stateNxt = IDLE;
`endif
                    end
                end
            end
`ifdef RESULT_FORMATTER_NEWLINE_EN
            NEWLINE: begin
                if (xfer) begin
                    validNxt = 1'b0;
                    lastNxt  = 1'b0;
                    busyNxt  = 1'b0;
                    doneNxt  = 1'b1;
                    stateNxt = IDLE;
                end
            end
`endif
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            neg       <= 1'b0;
            mag       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            idx       <= '0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= stateNxt;
            neg       <= negNxt;
            mag       <= magNxt;
            bcd       <= bcdNxt;
            cnt       <= cntNxt;
            idx       <= idxNxt;
            out_char  <= charNxt;
            out_valid <= validNxt;
            out_last  <= lastNxt;
            busy      <= busyNxt;
            done      <= doneNxt;
        end
    end

endmodule

// File: tb/tb_result_formatter.sv
// tb_result_formatter: directed checks of result_formatter strings,
// latency, backpressure, ignored start and mid-stream reset.

module tb_result_formatter;

    localparam int W = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] value = '0;
    logic         busy;
    logic [7:0]   out_char;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic         done;

    int checks = 0;
    int errors = 0;

    result_formatter #(.W(W), .DIGITS(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .out_char  (out_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic runNumber(input logic [W-1:0] v, input string s,
                             input int stallIdx, input int stallLen,
                             input bit poke);
        int    lat;
        string e;
        e = s;
`ifdef RESULT_FORMATTER_NEWLINE_EN
        e = {s, "\n"};
`endif
        value = v;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({s, ":busy_on"}, 64'(busy), 64'd1);
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (poke && lat == 5) begin
                value = ~v;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({s, ":latency"}, 64'(lat), 64'd51);
        for (int i = 0; i < e.len(); i++) begin
            if (i == stallIdx) begin
                out_ready = 1'b0;
                for (int c = 0; c < stallLen; c++) begin
                    @(posedge clk); #1;
                    check($sformatf("%s:stall_valid%0d", s, c),
                          64'(out_valid), 64'd1);
                    check($sformatf("%s:stall_char%0d", s, c),
                          64'(out_char), 64'(e[i]));
                    check($sformatf("%s:stall_last%0d", s, c),
                          64'(out_last), 64'd0);
                end
                out_ready = 1'b1;
            end
            check($sformatf("%s:valid%0d", s, i), 64'(out_valid), 64'd1);
            check($sformatf("%s:char%0d", s, i), 64'(out_char), 64'(e[i]));
            check($sformatf("%s:last%0d", s, i), 64'(out_last),
                  64'(i == e.len() - 1));
            @(posedge clk); #1;
        end
        check({s, ":done"}, 64'(done), 64'd1);
        check({s, ":busy_off"}, 64'(busy), 64'd0);
        check({s, ":valid_off"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({s, ":done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int lat;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_char", 64'(out_char), 64'h00);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero, small positive, negatives, boundaries
        runNumber(50'd0, "0", -1, 0, 1'b0);
        runNumber(50'd12345, "12345", -1, 0, 1'b1);
        runNumber(-50'sd7, "-7", -1, 0, 1'b0);
        runNumber(50'h2000000000000, "-562949953421312", -1, 0, 1'b0);
        runNumber(50'h1FFFFFFFFFFFF, "562949953421311", -1, 0, 1'b0);
        runNumber(50'd487654321098765, "487654321098765", 1, 3, 1'b0);

        // Reset in the middle of EMIT
        value = 50'd12345;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mid_latency", 64'(lat), 64'd51);
        check("mid_char0", 64'(out_char), 64'h31);
        repeat (2) @(posedge clk);
        #1;
        check("mid_char2", 64'(out_char), 64'h33);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        runNumber(50'd42, "42", -1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
